conv_0_mac_pipe: RTL
====================

// Module: conv_0_mac_pipe
// PURPOSE
//  Parametrised, pipelined signed multiply-accumulate for the conv_0 datapath; successor to the
//  combinational 16x8 multiplier. Adds configurable pipeline depth, valid/ready flow control,
//  per-beat MUL/MAC mode, and dot-product accumulation with optional saturation. Sits between
//  the line-buffer/weight fetch and the conv_0 output writer.
// PARAMETERS
//  DIN0_WIDTH  16  signed activation width
//  DIN1_WIDTH   8  signed weight width
//  ACC_WIDTH   32  accumulator/result width; must be >= DIN0_WIDTH+DIN1_WIDTH
//  NUM_STAGE    3  multiplier pipeline registers, legal 1..6
//  SATURATE     0  1 = clamp on accumulator overflow, 0 = two's-complement wrap
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           asynchronous, active-high reset
//  in_valid   in   1           input beat valid
//  in_ready   out  1           block can accept a beat this cycle
//  din0       in   DIN0_WIDTH  signed activation
//  din1       in   DIN1_WIDTH  signed weight
//  in_mode    in   1           0 = MUL (emit product), 1 = MAC (accumulate)
//  in_last    in   1           MAC only: final beat of dot product
//  out_valid  out  1           result valid
//  out_ready  in   1           downstream accepts result
//  dout       out  ACC_WIDTH   signed result
//  out_ovf    out  1           overflow occurred while forming this result
// BEHAVIOUR
//  - Reset: in_ready=0 while reset high, 1 on first cycle after; out_valid=0, dout=0, out_ovf=0,
//    all stage valids, accumulator and sticky ovf cleared. Reset mid-packet discards partial sum.
//  - Accept: beat taken when in_valid && in_ready. stall = out_valid && !out_ready;
//    in_ready = !stall. When stalled every pipeline stage and the accumulator hold.
//  - Product: full-precision signed DIN0*DIN1 -> (DIN0_WIDTH+DIN1_WIDTH) bits, sign-extended to
//    ACC_WIDTH; registered through NUM_STAGE stages, each carrying valid/mode/last.
//  - MUL beat: product loaded into output register; out_ovf=0. Latency NUM_STAGE+1 cycles from
//    accept to out_valid. Does not touch accumulator (may interleave with an open MAC packet).
//  - MAC beat, last=0: acc <= acc + product; no output.
//  - MAC beat, last=1: dout <= acc + product, out_valid=1, acc <= 0, ovf sticky cleared.
//    Single-beat packet (first beat last=1) yields the product alone. Latency NUM_STAGE+1.
//  - Overflow: detected on each add (operand signs equal, sum sign differs). SATURATE=1: sum
//    clamped to +2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1), clamped value kept in acc. SATURATE=0:
//    wrap. Either mode sets sticky ovf; out_ovf = sticky at the last beat.
//  - Output register: holds dout/out_ovf stable while out_valid && !out_ready. Same-cycle
//    out_ready and new result: old result retires, new one loads, out_valid stays 1.
//  - Throughput: one beat per cycle with out_ready held high; no bubbles.
//  - in_last ignored on MUL beats; in_mode/in_last ignored when in_valid=0.
// STRUCTURE
//  - Package conv_0_mac_pkg: MODE_MUL/MODE_MAC constants, stage sideband struct
//    {valid,mode,last}, functions sat_max(w)/sat_min(w).
//  - Sub-module conv_0_mac_mul_pipe: DSP-inferable signed multiplier with NUM_STAGE registers
//    and common enable (~stall); top holds sideband shift, accumulator, output register.
// TESTING
//  1 MUL: din0=-32768, din1=-128, mode=0 -> dout=4194304 after NUM_STAGE+1 cycles, out_ovf=0.
//  2 MAC 4 beats (100,3),(−50,2),(7,−1),(1,1 last) -> single result dout=194; acc 0 afterwards.
//  3 ACC_WIDTH=24, SATURATE=1: 300 beats of (32767,127) last on final -> dout=8388607, out_ovf=1;
//    SATURATE=0 same stimulus -> wrapped value matches model, out_ovf=1.
//  4 Back-pressure: stream of 20 MUL beats, out_ready toggling 1/0 randomly -> all 20 results
//    in order, none lost/duplicated, dout stable while stalled, in_ready=0 when stalled.
//  5 Interleave: MAC beats (2,2),(3,3) then MUL (5,5) then MAC (1,1 last) -> outputs 25 then 14.
//  6 Reset asserted mid-packet after 2 MAC beats, then new packet (4,4 last) -> dout=16, no
//    residue; out_valid low throughout reset.

Source files
------------

// File: rtl/conv_0_mac_pkg.sv
// conv_0_mac_pkg: shared mode constants, stage sideband type and saturation bounds for the conv_0 MAC
package conv_0_mac_pkg;
   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_MAC = 1'b1;
   typedef struct packed {
      logic valid;
      logic mode;
      logic last;
   } side_t;
   function automatic logic signed [63:0] sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction
   function automatic logic signed [63:0] sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction
endpackage

// File: rtl/conv_0_mac_mul_pipe.sv
// conv_0_mac_mul_pipe: signed full-precision multiplier followed by NUM_STAGE enabled pipeline registers
//   clk, reset : clock, asynchronous active-high reset
//   en_i       : common advance enable (low while the output stage is stalled)
//   a_i, b_i   : signed operands
//   p_o        : product, NUM_STAGE cycles after the operands were presented with en_i high
module conv_0_mac_mul_pipe #(
   parameter int A_W       = 16,
   parameter int B_W       = 8,
   parameter int NUM_STAGE = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en_i,
   input  logic signed [A_W-1:0]       a_i,
   input  logic signed [B_W-1:0]       b_i,
   output logic signed [A_W+B_W-1:0]   p_o
);
   localparam int P_W = A_W + B_W;
   logic signed [P_W-1:0] p_q [NUM_STAGE];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_STAGE; i++) p_q[i] <= '0;
      end else if (en_i) begin
         p_q[0] <= P_W'(a_i) * P_W'(b_i);
         for (int i = 1; i < NUM_STAGE; i++) p_q[i] <= p_q[i-1];
      end
   end
   assign p_o = p_q[NUM_STAGE-1];
endmodule

// File: rtl/conv_0_mac_pipe.sv
// conv_0_mac_pipe: pipelined signed MUL/MAC with valid/ready flow control and optional saturation
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid/in_ready    : input beat handshake
//   din0, din1           : signed activation / weight
//   in_mode, in_last     : 0 = MUL, 1 = MAC; in_last closes a MAC dot product
//   out_valid/out_ready  : result handshake
//   dout, out_ovf        : result and overflow flag for that result
module conv_0_mac_pipe import conv_0_mac_pkg::*; #(
   parameter int DIN0_WIDTH = 16,
   parameter int DIN1_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int NUM_STAGE  = 3,
   parameter bit SATURATE   = 1'b0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DIN0_WIDTH-1:0] din0,
   input  logic signed [DIN1_WIDTH-1:0] din1,
   input  logic                         in_mode,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [ACC_WIDTH-1:0]  dout,
   output logic                         out_ovf
);
   localparam int P_W = DIN0_WIDTH + DIN1_WIDTH;
   localparam int MSB = ACC_WIDTH - 1;
   localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] SMIN = ACC_WIDTH'(sat_min(ACC_WIDTH));
   if (NUM_STAGE < 1 || NUM_STAGE > 6 || ACC_WIDTH < P_W) begin : g_param_check
      $error("conv_0_mac_pipe: illegal NUM_STAGE or ACC_WIDTH");
   end
   logic                        stall, en;
   side_t                       side_in, s;
   side_t                       side_q [NUM_STAGE];
   logic signed [P_W-1:0]       prod;
   logic signed [ACC_WIDTH-1:0] prod_x, sum, sum_sat;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d, dout_q, dout_d;
   logic                        ovf_q, ovf_d, out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;
   logic                        add_ovf;
   // A held result freezes the whole pipe so nothing behind it is lost.
   assign stall    = out_valid_q & ~out_ready;
   assign en       = ~stall;
   assign in_ready = ~reset & ~stall;
   assign side_in  = '{valid: in_valid & in_ready, mode: in_mode, last: in_last};
   conv_0_mac_mul_pipe #(
      .A_W       (DIN0_WIDTH),
      .B_W       (DIN1_WIDTH),
      .NUM_STAGE (NUM_STAGE)
   ) u_mul (
      .clk   (clk),
      .reset (reset),
      .en_i  (en),
      .a_i   (din0),
      .b_i   (din1),
      .p_o   (prod)
   );
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_STAGE; i++) side_q[i] <= '0;
      end else if (en) begin
         side_q[0] <= side_in;
         for (int i = 1; i < NUM_STAGE; i++) side_q[i] <= side_q[i-1];
      end
   end
   assign s      = side_q[NUM_STAGE-1];
   assign prod_x = ACC_WIDTH'(prod);
   assign sum    = acc_q + prod_x;
   // Overflow: both operands share a sign the wrapped sum does not.
   assign add_ovf = (acc_q[MSB] == prod_x[MSB]) && (sum[MSB] != acc_q[MSB]);
   assign sum_sat = (SATURATE && add_ovf) ? (acc_q[MSB] ? SMIN : SMAX) : sum;
   always_comb begin
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      dout_d      = dout_q;
      out_ovf_d   = out_ovf_q;
      out_valid_d = out_valid_q & ~out_ready;
      if (en && s.valid) begin
         if (s.mode == MODE_MUL) begin
            out_valid_d = 1'b1;
            dout_d      = prod_x;
            out_ovf_d   = 1'b0;
         end else if (s.last) begin
            out_valid_d = 1'b1;
            dout_d      = sum_sat;
            out_ovf_d   = ovf_q | add_ovf;
            acc_d       = '0;
            ovf_d       = 1'b0;
         end else begin
            acc_d = sum_sat;
            ovf_d = ovf_q | add_ovf;
         end
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         dout_q      <= '0;
         out_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         dout_q      <= dout_d;
         out_ovf_q   <= out_ovf_d;
         out_valid_q <= out_valid_d;
      end
   end
   assign out_valid = out_valid_q;
   assign dout      = dout_q;
   assign out_ovf   = out_ovf_q;
endmodule
